// File: rtl/seg_scan_pkg.sv
// Shared constants, FSM state type and width helper for the 7-segment scan controller.
package seg_scan_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int SEL_W      = 3;
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      DEAD,
      ON
   } state_t;

   // Ceiling log2 with a floor of 1 bit, for sizing counters.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/seg_slot_counter.sv
// Per-digit slot timer: down-counter reloaded at each slot start, with terminal
// pulses for the last dead-time cycle and the last cycle of the slot.
module seg_slot_counter
   import seg_scan_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int DEAD_CYCLES  = 8
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr_i,
   input  logic load_i,
   input  logic run_i,
   output logic dead_done_o,
   output logic slot_done_o
);

   localparam int CW = clog2(DIGIT_CYCLES);
   localparam logic [CW-1:0] TOP       = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'(DIGIT_CYCLES - DEAD_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = TOP;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Count runs TOP..0 across a slot, so the dead phase ends DEAD_CYCLES below TOP.
   assign dead_done_o = run_i && (cnt_q == DEAD_LAST);
   assign slot_done_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller with dead-time, frame-aligned mask
// updates and frame-counted blinking.
//
// state | meaning
// IDLE  | scan stopped, anodes off, sel=0, slot/frame counters cleared
// DEAD  | leading dead-time of the current digit slot, anodes off
// ON    | current digit may light according to the active masks
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int DEAD_CYCLES  = 8,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic                  load,
   input  logic [NUM_DIGITS-1:0] digit_en_in,
   input  logic [NUM_DIGITS-1:0] blink_in,
   output logic [SEL_W-1:0]      sel,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  blank,
   output logic                  frame_start,
   output logic                  load_ack
);

   localparam int FW = clog2(BLINK_FRAMES + 1);
   localparam logic [FW-1:0]    FRAME_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DIGITS - 1);

   state_t                state_q, state_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  blank_q, blank_d;
   logic                  fs_q, fs_d;
   logic                  ack_q, ack_d;
   logic [NUM_DIGITS-1:0] act_en_q, act_en_d;
   logic [NUM_DIGITS-1:0] act_bl_q, act_bl_d;
   logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d;
   logic [NUM_DIGITS-1:0] pend_bl_q, pend_bl_d;
   logic                  pend_q, pend_d;
   logic                  phase_q, phase_d;
   logic [FW-1:0]         frame_q, frame_d;

   logic boundary;
   logic cnt_clr;
   logic cnt_load;
   logic dead_done;
   logic slot_done;
   logic lit;

   seg_slot_counter #(
      .DIGIT_CYCLES (DIGIT_CYCLES),
      .DEAD_CYCLES  (DEAD_CYCLES)
   ) u_slot (
      .clk         (clk),
      .rstn        (rstn),
      .clr_i       (cnt_clr),
      .load_i      (cnt_load),
      .run_i       (state_q != IDLE),
      .dead_done_o (dead_done),
      .slot_done_o (slot_done)
   );

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      act_en_d  = act_en_q;
      act_bl_d  = act_bl_q;
      pend_en_d = pend_en_q;
      pend_bl_d = pend_bl_q;
      pend_d    = pend_q;
      phase_d   = phase_q;
      frame_d   = frame_q;
      fs_d      = 1'b0;
      ack_d     = 1'b0;
      boundary  = 1'b0;
      cnt_load  = 1'b0;
      an_d      = ANODE_OFF;
      blank_d   = 1'b1;
      lit       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d  = DEAD;
               sel_d    = '0;
               boundary = 1'b1;
               cnt_load = 1'b1;
            end
         end
         DEAD: begin
            if (!en)
               state_d = IDLE;
            else if (dead_done)
               state_d = ON;
         end
         ON: begin
            if (!en) begin
               state_d = IDLE;
            end else if (slot_done) begin
               state_d  = DEAD;
               sel_d    = sel_q + SEL_W'(1);
               cnt_load = 1'b1;
               // The frame counter tracks completed frames, so only a wrap advances it.
               if (sel_q == SEL_LAST) begin
                  boundary = 1'b1;
                  if (frame_q == FRAME_LAST) begin
                     frame_d = '0;
                     phase_d = !phase_q;
                  end else begin
                     frame_d = frame_q + FW'(1);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == IDLE) begin
         sel_d   = '0;
         frame_d = '0;
      end

      // A load seen on the boundary edge bypasses the shadow registers.
      if (boundary) begin
         fs_d = 1'b1;
         if (load) begin
            act_en_d = digit_en_in;
            act_bl_d = blink_in;
            pend_d   = 1'b0;
            ack_d    = 1'b1;
         end else if (pend_q) begin
            act_en_d = pend_en_q;
            act_bl_d = pend_bl_q;
            pend_d   = 1'b0;
            ack_d    = 1'b1;
         end
      end else if (load) begin
         pend_en_d = digit_en_in;
         pend_bl_d = blink_in;
         pend_d    = 1'b1;
      end

      // Masks and phase only change on entry to DEAD, so ON always sees settled values.
      lit = act_en_q[sel_q] && !(act_bl_q[sel_q] && phase_q);
      if ((state_d == ON) && lit) begin
         an_d    = ~(NUM_DIGITS'(1) << sel_q);
         blank_d = 1'b0;
      end
   end

   assign cnt_clr = (state_d == IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         an_q      <= ANODE_OFF;
         blank_q   <= 1'b1;
         fs_q      <= 1'b0;
         ack_q     <= 1'b0;
         act_en_q  <= '1;
         act_bl_q  <= '0;
         pend_en_q <= '0;
         pend_bl_q <= '0;
         pend_q    <= 1'b0;
         phase_q   <= 1'b0;
         frame_q   <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         an_q      <= an_d;
         blank_q   <= blank_d;
         fs_q      <= fs_d;
         ack_q     <= ack_d;
         act_en_q  <= act_en_d;
         act_bl_q  <= act_bl_d;
         pend_en_q <= pend_en_d;
         pend_bl_q <= pend_bl_d;
         pend_q    <= pend_d;
         phase_q   <= phase_d;
         frame_q   <= frame_d;
      end
   end

   assign sel         = sel_q;
   assign an          = an_q;
   assign blank       = blank_q;
   assign frame_start = fs_q;
   assign load_ack    = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed frame/load/blink/enable/reset scenarios plus
// random traffic, all compared against a time-index reference model.
module tb_seg_scan_ctrl;

   localparam int DC    = 10;
   localparam int DD    = 2;
   localparam int BF    = 2;
   localparam int FRAME = 8 * DC;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [7:0] den_i = 8'h00;
   logic [7:0] bl_i = 8'h00;
   logic [2:0] sel;
   logic [7:0] an;
   logic       blank;
   logic       frame_start;
   logic       load_ack;

   int checks = 0;
   int errors = 0;

   seg_scan_ctrl #(
      .DIGIT_CYCLES (DC),
      .DEAD_CYCLES  (DD),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .load        (load),
      .digit_en_in (den_i),
      .blink_in    (bl_i),
      .sel         (sel),
      .an          (an),
      .blank       (blank),
      .frame_start (frame_start),
      .load_ack    (load_ack)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: position in the scan is derived from cycles since enable.
   bit         m_run;
   int         m_t;
   bit         m_base;
   bit         m_pend;
   bit         m_ack;
   logic [7:0] m_en, m_bl, m_pen, m_pbl;

   function automatic bit m_phase();
      return m_base ^ ((((m_t / FRAME) / BF) % 2) == 1);
   endfunction

   task automatic model_reset();
      m_run = 0; m_t = 0; m_base = 0; m_pend = 0; m_ack = 0;
      m_en = 8'hFF; m_bl = 8'h00; m_pen = 8'h00; m_pbl = 8'h00;
   endtask

   task automatic model_step();
      bit bnd;
      bnd   = 0;
      m_ack = 0;
      if (!m_run) begin
         if (en) begin
            m_run = 1; m_t = 0; bnd = 1;
         end
      end else if (!en) begin
         m_base = m_phase();
         m_run  = 0;
         m_t    = 0;
      end else begin
         m_t++;
         bnd = (m_t % FRAME) == 0;
      end
      if (bnd) begin
         if (load) begin
            m_en = den_i; m_bl = bl_i; m_pend = 0; m_ack = 1;
         end else if (m_pend) begin
            m_en = m_pen; m_bl = m_pbl; m_pend = 0; m_ack = 1;
         end
      end else if (load) begin
         m_pen = den_i; m_pbl = bl_i; m_pend = 1;
      end
   endtask

   task automatic model_check();
      logic [7:0] e_an;
      logic [2:0] e_sel;
      logic       e_blank, e_fs;
      int         d, pos;
      e_an = 8'hFF; e_blank = 1'b1; e_fs = 1'b0; e_sel = 3'd0;
      if (m_run) begin
         d     = (m_t / DC) % 8;
         pos   = m_t % DC;
         e_sel = 3'(d);
         e_fs  = (m_t % FRAME) == 0;
         if (pos >= DD && m_en[d] && !(m_bl[d] && m_phase())) begin
            e_an    = ~(8'h01 << d);
            e_blank = 1'b0;
         end
      end
      check_eq("sel", {5'b0, sel}, {5'b0, e_sel});
      check_eq("an", an, e_an);
      check_eq("blank", {7'b0, blank}, {7'b0, e_blank});
      check_eq("frame_start", {7'b0, frame_start}, {7'b0, e_fs});
      check_eq("load_ack", {7'b0, load_ack}, {7'b0, m_ack});
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rstn) model_reset();
      else model_step();
      #1;
      model_check();
   endtask

   task automatic run_rand(input int n, input int p_load, input int p_toggle);
      for (int i = 0; i < n; i++) begin
         den_i = 8'($urandom);
         bl_i  = 8'($urandom);
         load  = ($urandom_range(99) < p_load);
         if ($urandom_range(999) < p_toggle) en = ~en;
         tick();
      end
      load = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) tick();
      rstn = 1'b1;
      tick();

      // Directed run; iteration c's inputs are sampled at the edge that opens cycle c.
      en = 1'b1;
      tick();
      check_eq("fs_c0", {7'b0, frame_start}, 8'h01);
      for (int c = 1; c <= 700; c++) begin
         load = 1'b0;
         if (c == 31)  begin load = 1'b1; den_i = 8'h0F; bl_i = 8'h00; end
         if (c == 101) begin load = 1'b1; den_i = 8'h3C; bl_i = 8'h00; end
         if (c == 131) begin load = 1'b1; den_i = 8'hF0; bl_i = 8'h00; end
         if (c == 171) begin load = 1'b1; den_i = 8'hFF; bl_i = 8'h01; end
         if (c == 560) begin load = 1'b1; den_i = 8'h55; bl_i = 8'h00; end
         if (c == 606) en = 1'b0;
         if (c == 610) en = 1'b1;
         tick();
         if (c == 1)   check_eq("an_dead_c1", an, 8'hFF);
         if (c == 2)   check_eq("an_d0_on", an, 8'hFE);
         if (c == 10)  check_eq("sel_c10", {5'b0, sel}, 8'h01);
         if (c == 12)  check_eq("an_d1_on", an, 8'hFD);
         if (c == 80)  check_eq("ack_c80", {7'b0, load_ack}, 8'h01);
         if (c == 102) check_eq("an_mask0F_d2", an, 8'hFB);
         if (c == 122) check_eq("an_mask0F_d4", an, 8'hFF);
         if (c == 160) check_eq("fs_c160", {7'b0, frame_start}, 8'h01);
         if (c == 182) check_eq("an_lastwins_d2", an, 8'hFF);
         if (c == 202) check_eq("an_lastwins_d4", an, 8'hEF);
         if (c == 242) check_eq("an_blink_off", an, 8'hFF);
         if (c == 322) check_eq("an_blink_on", an, 8'hFE);
         if (c == 482) check_eq("an_blink_off2", an, 8'hFF);
         if (c == 560) check_eq("ack_bypass", {7'b0, load_ack}, 8'h01);
         if (c == 572) check_eq("an_bypass_d1", an, 8'hFF);
         if (c == 606) check_eq("sel_disabled", {5'b0, sel}, 8'h00);
         if (c == 610) check_eq("fs_restart", {7'b0, frame_start}, 8'h01);
      end
      load = 1'b0;

      // Async reset while digit 2 is lit and a load is pending.
      repeat (13) tick();
      check_eq("an_pre_reset", an, 8'hFB);
      load = 1'b1; den_i = 8'h00; bl_i = 8'hFF;
      tick();
      load = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check_eq("async_an", an, 8'hFF);
      check_eq("async_blank", {7'b0, blank}, 8'h01);
      model_reset();
      repeat (2) tick();
      rstn = 1'b1;
      repeat (100) tick();

      run_rand(3000, 5, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
